syn_clk_div_bank: RTL
=====================

# syn_clk_div_bank

Parametrised bank of programmable clock dividers and reset-pulse sequencer, controlled over the cortex local bus. It produces NUM_CHNLS divided clock outputs from one system clock, each with its own half-period and start delay, plus per-toggle ticks. It also produces a software-triggerable active-low reset pulse. The block replaces fixed free-running MCLK/reset generation with a register-programmable, synthesizable equivalent that sits beside the audio codec and PWM paths inside the cortex.

## Interface
- NUM_CHNLS, 4, number of divider channels (1..32)
- CNT_W, 16, width of half-period, delay and pulse-width counters (≤30)
- LB_ADDR_W, 8, local-bus word address width; requires 2+2*NUM_CHNLS ≤ 2^LB_ADDR_W
- RST_HOLD, 16, cycles sw_rst_ol stays low after rst_il release (≥1)

- clk_ir  in  1  system clock
- rst_il  in  1  asynchronous, active-low reset
- av_read_ih  in  1  local-bus read strobe
- av_write_ih  in  1  local-bus write strobe
- av_addr_id  in  LB_ADDR_W  word address
- av_write_data_id  in  32  write data
- av_wait_req_oh  out  1  read stall
- av_read_data_valid_oh  out  1  read data valid
- av_read_data_od  out  32  read data
- clk_div_od  out  NUM_CHNLS  divided clock per channel
- tick_oh  out  NUM_CHNLS  1-cycle pulse on every toggle of clk_div_od[i]
- sw_rst_ol  out  1  generated reset, active low

## Operation
- Register map (word addresses):
  - 0 CTRL: bit i = channel i enable.
  - 1 RSTC: [CNT_W-1:0] pulse width W. Writing with bit31=1 triggers a pulse. Reads return {busy,0…,W}; busy = pulse in progress.
  - 2+2i HALF_i: half-period H.
  - 3+2i DLY_i: start delay D.
  - Unmapped reads return 0; unmapped writes are ignored.
- Reset values: CTRL=0, W=1, H=1, D=0.
- Channel FSM: IDLE → DELAY when its enable is 1. DELAY → RUN after D cycles. In RUN, the channel toggles every H cycles. Clearing the enable in any state → IDLE.
- H=0 behaves as 1. W=0 behaves as 1.
- H is latched into a shadow register on entry to RUN and at each toggle. A write to HALF_i mid-run therefore takes effect after the next toggle; the current half-period is never truncated.
- A write to DLY_i affects only the next entry into DELAY.
- IDLE: clk_div_od[i]=0, tick_oh[i]=0, counters cleared.
- Re-enabling a channel restarts it from DELAY. Channels enabled by the same CTRL write with equal D are phase-aligned.
- Reset pulse: a trigger drives sw_rst_ol low for W cycles, then high.
  - A trigger during an active pulse restarts the count with the new W.
  - After rst_il deasserts, sw_rst_ol stays low for RST_HOLD cycles, then goes high.

## Timing
- Reset values of all outputs: clk_div_od=0, tick_oh=0, sw_rst_ol=0, av_wait_req_oh=0, av_read_data_valid_oh=0, av_read_data_od=0.
- Writes: registers update on the clk_ir edge that samples av_write_ih=1.
- Reads: av_read_data_valid_oh=1 with data exactly 1 cycle after an accepted read; valid is a single pulse; data is held until the next read.
- Read and write in the same cycle: the write is accepted. av_wait_req_oh=1 combinationally that cycle, and the master must hold the read. The read is accepted the next cycle unless another write arrives.
- Channel start: the enable is registered on edge E. clk_div_od[i] rises on edge E+D+1 and tick_oh[i] pulses with it. After that, it toggles every H cycles, giving period 2H.
- Channel stop: disable registered on edge E → clk_div_od[i]=0 from E+1, regardless of phase.
- Pulse: trigger write on edge E → sw_rst_ol=0 on E+1 through E+W, and 1 at E+W+1.
- Asynchronous reset mid-operation clears all state immediately; channels return to IDLE.

## Test plan
- Reset: assert rst_il, release → all outputs 0 and CTRL reads 0. sw_rst_ol rises exactly 16 cycles after release; HALF_0 reads 1.
- Single channel: HALF_0=3, DLY_0=0, CTRL=1 → clk_div_od[0] first rises 1 cycle after enable, period 6. tick_oh[0] pulses every 3 cycles.
- Phase offset: HALF_0=HALF_1=2, DLY_0=0, DLY_1=2, CTRL=3 → clk_div_od[1] lags clk_div_od[0] by exactly 2 cycles, both with period 4.
- Mid-run change and stop:
  - HALF_0=4 running, write HALF_0=1 → the current 4-cycle half completes, then the channel toggles every cycle.
  - Then CTRL=0 → output 0 the next cycle.
- Reset pulse: RSTC=0x8000_0005 → sw_rst_ol low for exactly 5 cycles. A retrigger with W=2 at cycle 3 → low through cycle 5, high at cycle 6. RSTC reads busy=1 during the pulse.
- Bus collision: read addr 2 with a simultaneous write to addr 0 → av_wait_req_oh=1 for that cycle. The read is accepted next cycle; valid 1 cycle later with data 1.

Source files
------------

// File: rtl/syn_clk_div_bank.sv
// Bank of programmable clock dividers plus a software-triggered reset-pulse
// generator, all configured over the cortex local bus.
module syn_clk_div_bank #(
  parameter int unsigned NUM_CHNLS = 4,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned LB_ADDR_W = 8,
  parameter int unsigned RST_HOLD  = 16
) (
  input  logic                 clk_ir,
  input  logic                 rst_il,
  input  logic                 av_read_ih,
  input  logic                 av_write_ih,
  input  logic [LB_ADDR_W-1:0] av_addr_id,
  input  logic [31:0]          av_write_data_id,
  output logic                 av_wait_req_oh,
  output logic                 av_read_data_valid_oh,
  output logic [31:0]          av_read_data_od,
  output logic [NUM_CHNLS-1:0] clk_div_od,
  output logic [NUM_CHNLS-1:0] tick_oh,
  output logic                 sw_rst_ol
);

  localparam int unsigned HOLD_W = $clog2(RST_HOLD + 1);
  localparam int unsigned PCNT_W = (CNT_W > HOLD_W) ? CNT_W : HOLD_W;

  typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_RUN} ch_state_e;

  logic [NUM_CHNLS-1:0]            r_ctrl;
  logic [CNT_W-1:0]                r_pw;
  logic [NUM_CHNLS-1:0][CNT_W-1:0] r_half_cfg;
  logic [NUM_CHNLS-1:0][CNT_W-1:0] r_dly_cfg;
  logic                            r_trig;
  logic [PCNT_W-1:0]               r_pcnt;
  logic                            r_sw_rst;
  logic                            r_rd_valid;
  logic [31:0]                     r_rd_data;

  logic                            w_rd_en;
  logic                            w_busy;
  logic [CNT_W-1:0]                w_pw_eff;
  logic [31:0]                     w_rd_data;
  logic                            w_unused_wdata;

  // A write wins a collision; the stalled read is retried by the master.
  assign w_rd_en        = av_read_ih & ~av_write_ih;
  assign av_wait_req_oh = av_read_ih & av_write_ih;
  assign w_busy         = r_trig | (r_pcnt != '0);
  assign w_pw_eff       = (r_pw == '0) ? CNT_W'(1) : r_pw;
  assign w_unused_wdata = ^av_write_data_id;

  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      r_ctrl     <= '0;
      r_pw       <= CNT_W'(1);
      r_half_cfg <= {NUM_CHNLS{CNT_W'(1)}};
      r_dly_cfg  <= '0;
      r_trig     <= 1'b0;
    end else begin
      r_trig <= 1'b0;
      if (av_write_ih) begin
        if (av_addr_id == LB_ADDR_W'(0)) r_ctrl <= av_write_data_id[NUM_CHNLS-1:0];
        if (av_addr_id == LB_ADDR_W'(1)) begin
          r_pw   <= av_write_data_id[CNT_W-1:0];
          r_trig <= av_write_data_id[31];
        end
        for (int i = 0; i < NUM_CHNLS; i++) begin
          if (av_addr_id == LB_ADDR_W'(2 + 2 * i)) r_half_cfg[i] <= av_write_data_id[CNT_W-1:0];
          if (av_addr_id == LB_ADDR_W'(3 + 2 * i)) r_dly_cfg[i]  <= av_write_data_id[CNT_W-1:0];
        end
      end
    end
  end

  // Reset pulse: the power-on hold and software pulses share one down-counter.
  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      r_pcnt   <= PCNT_W'(RST_HOLD);
      r_sw_rst <= 1'b0;
    end else if (r_trig) begin
      r_pcnt   <= PCNT_W'(w_pw_eff);
      r_sw_rst <= 1'b0;
    end else if (r_pcnt != '0) begin
      if (r_pcnt == PCNT_W'(1)) r_sw_rst <= 1'b1;
      r_pcnt <= r_pcnt - PCNT_W'(1);
    end
  end

  assign sw_rst_ol = r_sw_rst;

  always_comb begin
    w_rd_data = '0;
    if (av_addr_id == LB_ADDR_W'(0)) w_rd_data = 32'(r_ctrl);
    if (av_addr_id == LB_ADDR_W'(1)) begin
      w_rd_data     = 32'(r_pw);
      w_rd_data[31] = w_busy;
    end
    for (int i = 0; i < NUM_CHNLS; i++) begin
      if (av_addr_id == LB_ADDR_W'(2 + 2 * i)) w_rd_data = 32'(r_half_cfg[i]);
      if (av_addr_id == LB_ADDR_W'(3 + 2 * i)) w_rd_data = 32'(r_dly_cfg[i]);
    end
  end

  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= w_rd_en;
      if (w_rd_en) r_rd_data <= w_rd_data;
    end
  end

  assign av_read_data_valid_oh = r_rd_valid;
  assign av_read_data_od       = r_rd_data;

  for (genvar gi = 0; gi < NUM_CHNLS; gi++) begin : g_chnl
    ch_state_e        r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0] r_shadow, w_shadow_nxt;
    logic [CNT_W-1:0] w_half_eff;
    logic             r_div, w_div_nxt;
    logic             r_tick, w_tick_nxt;

    assign w_half_eff = (r_half_cfg[gi] == '0) ? CNT_W'(1) : r_half_cfg[gi];

    always_ff @(posedge clk_ir or negedge rst_il) begin
      if (!rst_il) begin
        r_state  <= ST_IDLE;
        r_cnt    <= '0;
        r_shadow <= CNT_W'(1);
        r_div    <= 1'b0;
        r_tick   <= 1'b0;
      end else begin
        r_state  <= w_state_nxt;
        r_cnt    <= w_cnt_nxt;
        r_shadow <= w_shadow_nxt;
        r_div    <= w_div_nxt;
        r_tick   <= w_tick_nxt;
      end
    end

    // The half-period shadow reloads only on a toggle, so a live HALF write never truncates a phase.
    always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_shadow_nxt = r_shadow;
      w_div_nxt    = r_div;
      w_tick_nxt   = 1'b0;
      if (!r_ctrl[gi]) begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
        w_div_nxt   = 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (r_dly_cfg[gi] == '0) begin
              w_state_nxt  = ST_RUN;
              w_div_nxt    = 1'b1;
              w_tick_nxt   = 1'b1;
              w_shadow_nxt = w_half_eff;
              w_cnt_nxt    = CNT_W'(1);
            end else begin
              w_state_nxt = ST_DELAY;
              w_cnt_nxt   = r_dly_cfg[gi];
            end
          end
          ST_DELAY: begin
            if (r_cnt <= CNT_W'(1)) begin
              w_state_nxt  = ST_RUN;
              w_div_nxt    = 1'b1;
              w_tick_nxt   = 1'b1;
              w_shadow_nxt = w_half_eff;
              w_cnt_nxt    = CNT_W'(1);
            end else begin
              w_cnt_nxt = r_cnt - CNT_W'(1);
            end
          end
          ST_RUN: begin
            if (r_cnt >= r_shadow) begin
              w_div_nxt    = ~r_div;
              w_tick_nxt   = 1'b1;
              w_shadow_nxt = w_half_eff;
              w_cnt_nxt    = CNT_W'(1);
            end else begin
              w_cnt_nxt = r_cnt + CNT_W'(1);
            end
          end
          default: w_state_nxt = ST_IDLE;
        endcase
      end
    end

    assign clk_div_od[gi] = r_div;
    assign tick_oh[gi]    = r_tick;
  end

endmodule
